// File: rtl/led_ctrl.sv
// LED channel controller: per-channel OFF/ON/BLINK/PWM drive from a
// two-state configuration write port and shared blink/PWM time bases.
//   state | meaning
//   IDLE  | ready for a configuration write (cfg_ready=1)
//   WRITE | committing the captured write, or flagging it via cfg_err
module led_ctrl #(
  parameter int N_LED       = 10,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4:0]       cfg_idx,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_duty,
  output logic             cfg_err,
  output logic [N_LED-1:0] led_sig
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, state_nxt;
  logic             accept, commit, cap_ok;
  logic [4:0]       cap_idx;
  logic [1:0]       cap_mode;
  logic [7:0]       cap_duty;
  logic [1:0]       mode [N_LED];
  logic [7:0]       duty [N_LED];
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic [7:0]       pwm_cnt;
  logic [N_LED-1:0] drive;

  assign cap_ok = ({1'b0, cap_idx} < 6'(N_LED));
  assign tick   = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept    = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        commit    = cap_ok;
        cfg_err   = ~cap_ok;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_idx  <= '0;
      cap_mode <= '0;
      cap_duty <= '0;
    end else if (accept) begin
      cap_idx  <= cfg_idx;
      cap_mode <= cfg_mode;
      cap_duty <= cfg_duty;
    end
  end

  // Out-of-range indices match no channel, so a rejected write touches nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LED; i++) begin
        mode[i] <= 2'b00;
        duty[i] <= 8'd0;
      end
    end else if (commit) begin
      for (int i = 0; i < N_LED; i++) begin
        if (cap_idx == 5'(i)) begin
          mode[i] <= cap_mode;
          duty[i] <= cap_duty;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    drive = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode[i])
        2'b00:   drive[i] = 1'b0;
        2'b01:   drive[i] = 1'b1;
        2'b10:   drive[i] = blink_phase;
        default: drive[i] = (pwm_cnt < duty[i]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_sig <= '0;
    else        led_sig <= drive;
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with a fast time base (PRESCALE=4, BLINK_TICKS=2).
module tb_led_ctrl;

  localparam int N_LED = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [4:0]       cfg_idx;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_duty;
  logic             cfg_err;
  logic [N_LED-1:0] led_sig;

  int errors = 0;
  int checks = 0;

  led_ctrl #(.N_LED(N_LED), .PRESCALE(4), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .led_sig(led_sig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the write edge; led_sig reflects it one edge later.
  task automatic do_write(input logic [4:0] idx, input logic [1:0] md, input logic [7:0] dt);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_mode = md; cfg_duty = dt;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_high(input int bit_i, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (led_sig[bit_i]) hi++;
    end
  endtask

  initial begin
    int  cnt, n;
    logic v;
    logic [N_LED-1:0] snap;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_duty = '0;
    #1;
    check("rst_led", 32'(led_sig), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_err", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (led_sig != '0 || cfg_err) cnt++;
    end
    check("idle_1000", 32'(cnt), 0);

    // ON write to channel 3
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 5'd3; cfg_mode = 2'b01; cfg_duty = 8'd0;
    check("on_ready_pre", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("on_ready_busy", 32'(cfg_ready), 0);
    @(negedge clk);
    check("on_ready_back", 32'(cfg_ready), 1);
    check("on_led_e1", 32'(led_sig), 0);
    @(negedge clk);
    check("on_led_e2", 32'(led_sig), 32'h008);

    // Rewriting the same value must not disturb channel 3
    cnt = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 5'd3; cfg_mode = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (led_sig !== 10'h008) cnt++;
    end
    check("rewrite_glitch", 32'(cnt), 0);

    // BLINK on channel 0: 8 cycles high, 8 low
    do_write(5'd0, 2'b10, 8'd0);
    @(negedge clk);
    v = led_sig[0];
    n = 0;
    while (led_sig[0] == v && n < 20) begin @(negedge clk); n++; end
    check("blink_found_edge", 32'(n < 20), 1);
    for (int r = 0; r < 2; r++) begin
      v = led_sig[0];
      n = 0;
      do begin @(negedge clk); n++; end while (led_sig[0] == v && n < 40);
      check(r == 0 ? "blink_run_a" : "blink_run_b", 32'(n), 8);
    end
    count_high(0, 64, cnt);
    check("blink_duty", 32'(cnt), 32);
    check("blink_ch3_on", 32'(led_sig[3]), 1);

    // PWM on channel 1
    do_write(5'd1, 2'b11, 8'd64);
    repeat (2) @(negedge clk);
    count_high(1, 256, cnt);
    check("pwm_64", 32'(cnt), 64);
    do_write(5'd1, 2'b11, 8'd0);
    repeat (2) @(negedge clk);
    count_high(1, 256, cnt);
    check("pwm_0", 32'(cnt), 0);
    do_write(5'd1, 2'b11, 8'd255);
    repeat (2) @(negedge clk);
    count_high(1, 256, cnt);
    check("pwm_255", 32'(cnt), 255);
    count_high(0, 64, cnt);
    check("blink_after_pwm", 32'(cnt), 32);

    // Out-of-range write
    @(negedge clk);
    snap = led_sig;
    cfg_valid = 1'b1; cfg_idx = 5'd20; cfg_mode = 2'b01;
    check("err_idle", 32'(cfg_err), 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("err_pulse", 32'(cfg_err), 1);
    @(negedge clk);
    check("err_clear", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    check("err_led_unch", 32'(led_sig[9:2]), 32'(snap[9:2]));

    // Back-to-back valid; inputs changed during WRITE are ignored
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 5'd5; cfg_mode = 2'b01;
    check("b2b_ready0", 32'(cfg_ready), 1);
    @(negedge clk);
    check("b2b_ready1", 32'(cfg_ready), 0);
    cfg_idx = 5'd6;
    @(negedge clk);
    check("b2b_ready2", 32'(cfg_ready), 1);
    @(negedge clk);
    check("b2b_ready3", 32'(cfg_ready), 0);
    cfg_idx = 5'd7;
    @(negedge clk);
    check("b2b_ready4", 32'(cfg_ready), 1);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_leds", 32'(led_sig[9:2]), 32'h1A);

    // Reset during WRITE discards the pending write
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 5'd9; cfg_mode = 2'b01;
    @(negedge clk);
    check("mid_in_write", 32'(cfg_ready), 0);
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("mid_rst_led", 32'(led_sig), 0);
    check("mid_rst_ready", 32'(cfg_ready), 1);
    check("mid_rst_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (led_sig != '0) cnt++;
    end
    check("mid_rst_discard", 32'(cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
